multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the MIPS-subset datapath (PC, instruction register, register file, ALU, 64-word data RAM). It replaces single-cycle combinational decode with a Moore/Mealy FSM that steps each instruction through IF/ID/EX/MEM/WB. It emits per-state write enables, mux selects and the 3-bit ALU operation, and keeps a retired-instruction counter. It sits between the instruction register's op/funct fields and every enable/select in the datapath.

## Interface
Parameters:
- none; encodings fixed below

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- run  in  1  1 = fetch new instructions; 0 = finish current instruction, then idle in IF
- op_code  in  6  IR[31:26], stable from end of IF until next IF
- funct  in  6  IR[5:0]
- ZF  in  1  ALU zero flag (combinational from datapath)
- IR_Write  out  1  load instruction register
- PC_Write  out  1  load PC
- PC_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- Write_Reg  out  1  register-file write enable
- ALU_OP  out  3  ALU operation
- rd_rt_s  out  1  1 = write address rt, 0 = rd
- imm_s  out  1  1 = sign-extend immediate, 0 = zero-extend
- rt_imm_s  out  1  1 = ALU B from immediate, 0 = from rt
- Mem_Write  out  1  data-RAM write enable
- alu_mem_s  out  1  1 = write-back data from RAM, 0 = from ALU
- state  out  3  current state, for debug
- illegal  out  1  sticky unsupported-opcode/funct flag
- inst_count  out  32  retired-instruction count

## Operation
- States: IF=000, ID=001, EX=010, MEM=011, WB=100, ERR=111.
- IF:
  - run=1: IR_Write=1, PC_Write=1, PC_src=00; next state ID.
  - run=0: no enables asserted; stay in IF.
- ID: register read; decode op_code/funct.
  - j (000010): PC_Write=1, PC_src=10; retire; next IF.
  - Any other supported op: next EX.
  - Unsupported op, or R-type with unsupported funct: next ERR.
- EX: ALU active with ALU_OP and the selects below.
  - beq (000100): ALU_OP=101 (sub), rt_imm_s=0. PC_Write=ZF (Mealy), PC_src=01; retire; next IF.
  - lw/sw: next MEM.
  - All other ops: next WB.
- MEM:
  - sw: Mem_Write=1; retire; next IF.
  - lw: RAM read issued; next WB.
- WB: Write_Reg=1; retire; next IF.
  - lw: alu_mem_s=1, rd_rt_s=1.
  - I-type ALU: rd_rt_s=1.
  - R-type: rd_rt_s=0.
- R-type (op 000000) funct to ALU_OP:
  - 100100 and = 000
  - 100101 or = 001
  - 100110 xor = 010
  - 100111 nor = 011
  - 100000 add = 100
  - 100010 sub = 101
  - 101011 sltu = 110
  - 000100 sllv = 111
- I-type ALU ops (rt_imm_s=1):
  - addi 001000 = 100, imm_s=1
  - andi 001100 = 000, imm_s=0
  - ori 001101 = 001, imm_s=0
  - xori 001110 = 010, imm_s=0
  - sltiu 001011 = 110, imm_s=1
- lw 100011 / sw 101011: ALU_OP=100, imm_s=1, rt_imm_s=1 in EX and MEM. For lw, these selects also hold in WB.
- Selects and ALU_OP hold their decoded values through every state of the instruction. Enables are asserted only in the states listed above.
- ERR: all enables 0; illegal=1. ERR is exited only by reset.
- inst_count increments by 1 on each retire edge. It wraps from FFFF_FFFF to 0000_0000.

## Timing
- Cycles per instruction:
  - j: 2
  - beq: 3
  - R-type, I-type ALU, sw: 4
  - lw: 5
- RAM has 1-cycle read latency: the address is presented in MEM, and data is valid and written back in WB.
- PC+4 and IR load happen on the same IF edge. The branch target is computed from the already-incremented PC.
- Reset:
  - rst=0 at any rising edge forces state=IF, illegal=0, inst_count=0, overriding every other condition, including mid-instruction and in ERR.
  - While rst=0, all enables (IR_Write, PC_Write, Write_Reg, Mem_Write) are 0 combinationally. All selects, PC_src and ALU_OP are 0.
- run is sampled only in IF. Deasserting run mid-instruction does not stall the instruction.
- beq with ZF=0: no PC write in EX. The instruction still retires.

## Test plan
- Reset and run: hold rst=0 for 2 cycles with run=1 → state=000, all enables 0, inst_count=0. Release rst → IR_Write=PC_Write=1 in the first cycle.
- R-type add (op 000000, funct 100000) → states IF,ID,EX,WB. WB has Write_Reg=1, ALU_OP=100, rd_rt_s=0, rt_imm_s=0. inst_count 0→1.
- lw then sw → lw takes 5 cycles, with alu_mem_s=1 and Write_Reg=1 only in WB. sw takes 4 cycles, with Mem_Write=1 only in MEM. inst_count=2.
- beq with ZF=1, then with ZF=0 → PC_Write=1, PC_src=01 in EX only for the ZF=1 case. Both take 3 cycles.
- j followed by run=0 → j takes 2 cycles with PC_src=10. The controller then idles in IF with no enables while inst_count stays constant.
- Illegal op 111111 → ERR at cycle 3, illegal=1, stays there for 20 cycles. rst=0 for one cycle clears it, giving state=000 and illegal=0. Also preload inst_count near wrap and check FFFF_FFFF→0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for the MIPS-subset datapath.
// Decodes op_code/funct into enables, selects and ALU_OP, and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  op_code,
  input  logic [5:0]  funct,
  input  logic        ZF,
  output logic        IR_Write,
  output logic        PC_Write,
  output logic [1:0]  PC_src,
  output logic        Write_Reg,
  output logic [2:0]  ALU_OP,
  output logic        rd_rt_s,
  output logic        imm_s,
  output logic        rt_imm_s,
  output logic        Mem_Write,
  output logic        alu_mem_s,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] inst_count
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100,
    S_ERR = 3'b111
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t      r_state;
  state_t      w_next;
  logic        r_illegal;
  logic [31:0] r_inst_count;
  logic        w_retire;

  logic [2:0]  w_alu_op;
  logic        w_imm_s;
  logic        w_rt_imm_s;
  logic        w_rd_rt_s;
  logic        w_legal;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_is_beq;
  logic        w_is_j;

  assign w_is_lw  = (op_code == OP_LW);
  assign w_is_sw  = (op_code == OP_SW);
  assign w_is_beq = (op_code == OP_BEQ);
  assign w_is_j   = (op_code == OP_J);

  // Instruction decode: valid whenever the IR holds the current instruction (ID onward).
  always_comb begin
    w_alu_op   = 3'b000;
    w_imm_s    = 1'b0;
    w_rt_imm_s = 1'b0;
    w_rd_rt_s  = 1'b0;
    w_legal    = 1'b1;
    case (op_code)
      OP_R: begin
        case (funct)
          6'b100100: w_alu_op = 3'b000;
          6'b100101: w_alu_op = 3'b001;
          6'b100110: w_alu_op = 3'b010;
          6'b100111: w_alu_op = 3'b011;
          6'b100000: w_alu_op = 3'b100;
          6'b100010: w_alu_op = 3'b101;
          6'b101011: w_alu_op = 3'b110;
          6'b000100: w_alu_op = 3'b111;
          default:   w_legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_alu_op = 3'b100; w_imm_s = 1'b1; w_rt_imm_s = 1'b1; w_rd_rt_s = 1'b1;
      end
      OP_ANDI: begin
        w_alu_op = 3'b000; w_rt_imm_s = 1'b1; w_rd_rt_s = 1'b1;
      end
      OP_ORI: begin
        w_alu_op = 3'b001; w_rt_imm_s = 1'b1; w_rd_rt_s = 1'b1;
      end
      OP_XORI: begin
        w_alu_op = 3'b010; w_rt_imm_s = 1'b1; w_rd_rt_s = 1'b1;
      end
      OP_SLTIU: begin
        w_alu_op = 3'b110; w_imm_s = 1'b1; w_rt_imm_s = 1'b1; w_rd_rt_s = 1'b1;
      end
      OP_LW, OP_SW: begin
        w_alu_op = 3'b100; w_imm_s = 1'b1; w_rt_imm_s = 1'b1; w_rd_rt_s = w_is_lw;
      end
      OP_BEQ: w_alu_op = 3'b101;
      OP_J:   w_alu_op = 3'b000;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    IR_Write  = 1'b0;
    PC_Write  = 1'b0;
    PC_src    = 2'b00;
    Write_Reg = 1'b0;
    Mem_Write = 1'b0;
    alu_mem_s = 1'b0;
    ALU_OP    = 3'b000;
    rd_rt_s   = 1'b0;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;
    if (rst) begin
      if (r_state != S_IF && r_state != S_ERR) begin
        ALU_OP   = w_alu_op;
        rd_rt_s  = w_rd_rt_s;
        imm_s    = w_imm_s;
        rt_imm_s = w_rt_imm_s;
      end
      case (r_state)
        S_IF: begin
          if (run) begin
            IR_Write = 1'b1;
            PC_Write = 1'b1;
            w_next   = S_ID;
          end
        end
        S_ID: begin
          if (w_is_j) begin
            PC_Write = 1'b1;
            PC_src   = 2'b10;
            w_retire = 1'b1;
            w_next   = S_IF;
          end else if (w_legal) begin
            w_next = S_EX;
          end else begin
            w_next = S_ERR;
          end
        end
        S_EX: begin
          if (w_is_beq) begin
            PC_Write = ZF;
            PC_src   = 2'b01;
            w_retire = 1'b1;
            w_next   = S_IF;
          end else if (w_is_lw || w_is_sw) begin
            w_next = S_MEM;
          end else begin
            w_next = S_WB;
          end
        end
        S_MEM: begin
          if (w_is_sw) begin
            Mem_Write = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_IF;
          end else begin
            w_next = S_WB;
          end
        end
        S_WB: begin
          Write_Reg = 1'b1;
          alu_mem_s = w_is_lw;
          w_retire  = 1'b1;
          w_next    = S_IF;
        end
        S_ERR:   w_next = S_ERR;
        default: w_next = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IF;
      r_illegal    <= 1'b0;
      r_inst_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ERR) r_illegal <= 1'b1;
      if (w_retire) r_inst_count <= r_inst_count + 32'd1;
    end
  end

  assign state      = r_state;
  assign illegal    = r_illegal;
  assign inst_count = r_inst_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expectations are queued per instruction
// and popped/compared each cycle.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [5:0]  op_code;
  logic [5:0]  funct;
  logic        ZF;
  logic        IR_Write;
  logic        PC_Write;
  logic [1:0]  PC_src;
  logic        Write_Reg;
  logic [2:0]  ALU_OP;
  logic        rd_rt_s;
  logic        imm_s;
  logic        rt_imm_s;
  logic        Mem_Write;
  logic        alu_mem_s;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] inst_count;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .op_code(op_code), .funct(funct), .ZF(ZF),
    .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_src(PC_src), .Write_Reg(Write_Reg),
    .ALU_OP(ALU_OP), .rd_rt_s(rd_rt_s), .imm_s(imm_s), .rt_imm_s(rt_imm_s),
    .Mem_Write(Mem_Write), .alu_mem_s(alu_mem_s), .state(state), .illegal(illegal),
    .inst_count(inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  typedef enum {C_R, C_I, C_LW, C_SW, C_BEQ, C_J, C_BAD} cls_t;

  typedef struct {
    logic [2:0]  st;
    logic        irw, pcw;
    logic [1:0]  pcs;
    logic        wr, memw, alum, ill;
    logic [31:0] cnt;
    logic        chk_pcs, chk_sel, chk_imm, chk_rdrt;
    logic [2:0]  aop;
    logic        rti, im, rdrt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_cnt = 32'd0;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic exp_t mk(input logic [2:0] st, input logic irw, input logic pcw,
                              input logic [1:0] pcs, input logic wr, input logic memw,
                              input logic alum, input logic ill);
    exp_t e;
    e.st = st; e.irw = irw; e.pcw = pcw; e.pcs = pcs;
    e.wr = wr; e.memw = memw; e.alum = alum; e.ill = ill;
    e.cnt = m_cnt;
    e.chk_pcs = pcw; e.chk_sel = 1'b0; e.chk_imm = 1'b0; e.chk_rdrt = 1'b0;
    e.aop = 3'd0; e.rti = 1'b0; e.im = 1'b0; e.rdrt = 1'b0;
    return e;
  endfunction

  function automatic exp_t sel(input exp_t ei, input logic [2:0] aop, input logic rti,
                               input logic im, input logic chk_i);
    exp_t e;
    e = ei;
    e.chk_sel = 1'b1; e.aop = aop; e.rti = rti;
    e.chk_imm = chk_i; e.im = im;
    return e;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    logic [40:0] obs, expv;
    e = sb.pop_front();
    obs  = {state, IR_Write, PC_Write, Write_Reg, Mem_Write, alu_mem_s, illegal, inst_count};
    expv = {e.st, e.irw, e.pcw, e.wr, e.memw, e.alum, e.ill, e.cnt};
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s ctrl {st,irw,pcw,wr,memw,alum,ill,cnt}: observed %h expected %h", tag, obs, expv);
    end
    if (e.chk_pcs) begin
      n_assert++;
      assert (PC_src === e.pcs) else begin
        n_fail++;
        $error("FAIL %s PC_src: observed %b expected %b", tag, PC_src, e.pcs);
      end
    end
    if (e.chk_sel) begin
      n_assert++;
      assert ({ALU_OP, rt_imm_s} === {e.aop, e.rti}) else begin
        n_fail++;
        $error("FAIL %s {ALU_OP,rt_imm_s}: observed %b expected %b", tag, {ALU_OP, rt_imm_s}, {e.aop, e.rti});
      end
    end
    if (e.chk_imm) begin
      n_assert++;
      assert (imm_s === e.im) else begin
        n_fail++;
        $error("FAIL %s imm_s: observed %b expected %b", tag, imm_s, e.im);
      end
    end
    if (e.chk_rdrt) begin
      n_assert++;
      assert (rd_rt_s === e.rdrt) else begin
        n_fail++;
        $error("FAIL %s rd_rt_s: observed %b expected %b", tag, rd_rt_s, e.rdrt);
      end
    end
    $display("%s st=%0d irw=%b pcw=%b pcs=%b wr=%b memw=%b alum=%b aop=%b ill=%b cnt=%h",
             tag, state, IR_Write, PC_Write, PC_src, Write_Reg, Mem_Write, alu_mem_s, ALU_OP,
             illegal, inst_count);
  endtask

  // Called at a falling edge; leaves rst high at the next falling edge.
  task automatic do_reset(input int n, input logic [2:0] st0, input logic ill0);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      e = mk((c == 0) ? st0 : 3'd0, L0, L0, 2'd0, L0, L0, L0, (c == 0) ? ill0 : L0);
      e.chk_pcs = 1'b1; e.chk_sel = 1'b1; e.chk_imm = 1'b1; e.chk_rdrt = 1'b1;
      sb.push_back(e);
      m_cnt = 32'd0;
    end
    for (int c = 0; c < n; c++) begin
      rst = 1'b0;
      #1 check($sformatf("reset[%0d]", c));
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  task automatic do_idle(input int n);
    for (int c = 0; c < n; c++) sb.push_back(mk(3'd0, L0, L0, 2'd0, L0, L0, L0, L0));
    for (int c = 0; c < n; c++) begin
      run = 1'b0;
      #1 check($sformatf("idle[%0d]", c));
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input cls_t cls, input logic zf, input logic run_mid,
                          input logic [2:0] aop, input logic rti, input logic im,
                          input logic rdrt);
    exp_t e;
    logic chk_i;
    chk_i = (cls == C_I || cls == C_LW || cls == C_SW);
    sb.push_back(mk(3'd0, L1, L1, 2'b00, L0, L0, L0, L0));
    case (cls)
      C_J: begin
        sb.push_back(mk(3'd1, L0, L1, 2'b10, L0, L0, L0, L0));
        m_cnt++;
      end
      C_BAD: begin
        sb.push_back(mk(3'd1, L0, L0, 2'b00, L0, L0, L0, L0));
        for (int k = 0; k < 20; k++) sb.push_back(mk(3'd7, L0, L0, 2'b00, L0, L0, L0, L1));
      end
      default: begin
        sb.push_back(sel(mk(3'd1, L0, L0, 2'b00, L0, L0, L0, L0), aop, rti, im, chk_i));
        if (cls == C_BEQ) begin
          sb.push_back(sel(mk(3'd2, L0, zf, 2'b01, L0, L0, L0, L0), aop, rti, im, L0));
          m_cnt++;
        end else begin
          sb.push_back(sel(mk(3'd2, L0, L0, 2'b00, L0, L0, L0, L0), aop, rti, im, chk_i));
          if (cls == C_SW) begin
            sb.push_back(sel(mk(3'd3, L0, L0, 2'b00, L0, L1, L0, L0), aop, rti, im, chk_i));
            m_cnt++;
          end else begin
            if (cls == C_LW)
              sb.push_back(sel(mk(3'd3, L0, L0, 2'b00, L0, L0, L0, L0), aop, rti, im, chk_i));
            e = sel(mk(3'd4, L0, L0, 2'b00, L1, L0, (cls == C_LW), L0), aop, rti, im, chk_i);
            e.chk_rdrt = 1'b1;
            e.rdrt = rdrt;
            sb.push_back(e);
            m_cnt++;
          end
        end
      end
    endcase
    op_code = op;
    funct = fn;
    ZF = zf;
    for (int c = 0; sb.size() > 0; c++) begin
      run = (c == 0) ? 1'b1 : run_mid;
      #1 check($sformatf("%s[%0d]", tag, c));
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b1;
    op_code = 6'b100011;
    funct = 6'b000000;
    ZF = 1'b0;
    @(negedge clk);
    do_reset(2, 3'd0, L0);

    //            tag      op         funct      cls    ZF  run  ALU_OP rti im  rdrt
    do_instr("add",   6'b000000, 6'b100000, C_R,   L0, L1, 3'b100, L0, L0, L0);
    do_instr("lw",    6'b100011, 6'b000000, C_LW,  L0, L1, 3'b100, L1, L1, L1);
    do_instr("sw",    6'b101011, 6'b000000, C_SW,  L0, L0, 3'b100, L1, L1, L0);
    do_instr("beq1",  6'b000100, 6'b000000, C_BEQ, L1, L1, 3'b101, L0, L0, L0);
    do_instr("beq0",  6'b000100, 6'b000000, C_BEQ, L0, L1, 3'b101, L0, L0, L0);
    do_instr("ori",   6'b001101, 6'b000000, C_I,   L0, L1, 3'b001, L1, L0, L1);
    do_instr("addi",  6'b001000, 6'b000000, C_I,   L0, L1, 3'b100, L1, L1, L1);
    do_instr("sltu",  6'b000000, 6'b101011, C_R,   L0, L1, 3'b110, L0, L0, L0);
    do_instr("sllv",  6'b000000, 6'b000100, C_R,   L0, L1, 3'b111, L0, L0, L0);
    do_instr("j",     6'b000010, 6'b000000, C_J,   L0, L0, 3'b000, L0, L0, L0);
    do_idle(5);

    do_instr("badop", 6'b111111, 6'b000000, C_BAD, L0, L1, 3'b000, L0, L0, L0);
    do_reset(1, 3'd7, L1);
    do_idle(1);
    do_instr("badfn", 6'b000000, 6'b111111, C_BAD, L0, L1, 3'b000, L0, L0, L0);
    do_reset(1, 3'd7, L1);
    do_idle(1);

    dut.r_inst_count = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    do_instr("wrap",  6'b000000, 6'b100100, C_R,   L0, L1, 3'b000, L0, L0, L0);
    do_idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
